irq_iack_resp: RTL and testbench

- CPU-side counterpart of the video IRQ priority encoder.
- Samples the encoded IPL1/IPL0 lines and qualifies them against the 68k status-register mask, then signals a pending interrupt to the CPU core.
- Answers the CPU's interrupt-acknowledge cycle with an autovector, or with a spurious-interrupt bus error.
- Optionally issues the matching acknowledge write (WR_ACK/ACK_BITS) back to the encoder, so the source clears without software.

---
 rtl/irq_iack_resp.sv | 147 ++++++++++++++
 tb/tb_irq_iack_resp.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_iack_resp.sv
// irq_iack_resp: CPU-side interrupt qualifier and IACK responder.
// Two-sample filters the encoded IPL lines, masks them against the 68k SR
// mask, answers IACK cycles with an autovector or a spurious bus error, and
// optionally writes the acknowledge back to the video IRQ encoder.
module irq_iack_resp #(
  parameter int unsigned AUTO_ACK    = 0,
  parameter int unsigned CLR_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       CLK_EN,
  input  logic       IPL0,
  input  logic       IPL1,
  input  logic [2:0] IMASK,
  input  logic       IACK_STB,
  input  logic [2:0] IACK_A,
  input  logic       IACK_END,
  output logic       INT_PEND,
  output logic [2:0] INT_LEVEL,
  output logic       nVPA,
  output logic       nBERR,
  output logic [7:0] VECTOR,
  output logic       WR_ACK,
  output logic [2:0] ACK_BITS
);

  localparam int unsigned CNT_W = (CLR_TIMEOUT < 2) ? 1 : $clog2(CLR_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((CLR_TIMEOUT == 0) ? 0 : CLR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IACK_AV,
    S_IACK_SP,
    S_ACKW,
    S_WAIT_CLR
  } state_t;

  state_t           state;
  logic [2:0]       raw;
  logic [2:0]       samp_a;
  logic [2:0]       samp_b;
  logic [2:0]       lvl_s;
  logic [2:0]       acked_level;
  logic [CNT_W-1:0] clr_cnt;
  logic             pend_d;

  // Decode the active-low encoded lines and qualify the stable level.
  always_comb begin
    raw    = {1'b0, ~IPL1, ~IPL0};
    pend_d = (lvl_s != 3'd0) && (lvl_s > IMASK) &&
             !((state == S_WAIT_CLR) && (lvl_s == acked_level));
  end

  // Two-deep sample pair; the stable level only follows two equal samples.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      samp_a <= '0;
      samp_b <= '0;
      lvl_s  <= '0;
    end else begin
      if (CLK_EN) begin
        samp_a <= raw;
        samp_b <= samp_a;
      end
      if (samp_a == samp_b) lvl_s <= samp_a;
    end
  end

  // Registered pending flag and level presented to the CPU core.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      INT_PEND  <= 1'b0;
      INT_LEVEL <= '0;
    end else begin
      INT_PEND  <= pend_d;
      INT_LEVEL <= pend_d ? lvl_s : 3'd0;
    end
  end

  // IACK response, acknowledge write and clear-wait sequencing.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state       <= S_IDLE;
      nVPA        <= 1'b1;
      nBERR       <= 1'b1;
      VECTOR      <= '0;
      WR_ACK      <= 1'b0;
      ACK_BITS    <= '0;
      acked_level <= '0;
      clr_cnt     <= '0;
    end else begin
      WR_ACK   <= 1'b0;
      ACK_BITS <= '0;
      case (state)
        S_IDLE: begin
          if (IACK_STB) begin
            // Compare against the registered INT_LEVEL the CPU actually saw.
            if ((IACK_A == INT_LEVEL) && (IACK_A != 3'd0)) begin
              state       <= S_IACK_AV;
              acked_level <= IACK_A;
              VECTOR      <= 8'h18 + {5'b0, IACK_A};
              nVPA        <= 1'b0;
            end else begin
              state  <= S_IACK_SP;
              VECTOR <= 8'h18;
              nBERR  <= 1'b0;
            end
          end
        end
        S_IACK_AV: begin
          if (IACK_END) begin
            nVPA  <= 1'b1;
            state <= (AUTO_ACK != 0) ? S_ACKW : S_IDLE;
          end
        end
        S_IACK_SP: begin
          if (IACK_END) begin
            nBERR <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ACKW: begin
          WR_ACK <= 1'b1;
          case (acked_level)
            3'd3:    ACK_BITS <= 3'b001;
            3'd2:    ACK_BITS <= 3'b010;
            3'd1:    ACK_BITS <= 3'b100;
            default: ACK_BITS <= 3'b000;
          endcase
          clr_cnt <= '0;
          state   <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          if (lvl_s != acked_level) begin
            state <= S_IDLE;
          end else if (CLK_EN) begin
            if (clr_cnt == CNT_LAST) state <= S_IDLE;
            else                     clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_iack_resp.sv
// tb_irq_iack_resp: vector table, directed corner sequences and a randomized
// run against a behavioural model, on a manual-ack and an auto-ack instance.
module tb_irq_iack_resp;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       nreset;
  logic       clk_en;
  logic       ipl0, ipl1;
  logic [2:0] imask;
  logic       iack_stb;
  logic [2:0] iack_a;
  logic       iack_end;

  logic       pend   [2];
  logic [2:0] level  [2];
  logic       vpa_n  [2];
  logic       berr_n [2];
  logic [7:0] vector [2];
  logic       wr_ack [2];
  logic [2:0] bits   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_iack_resp #(.AUTO_ACK(0), .CLR_TIMEOUT(TMO)) dut_man (
    .CLK(clk), .nRESET(nreset), .CLK_EN(clk_en), .IPL0(ipl0), .IPL1(ipl1),
    .IMASK(imask), .IACK_STB(iack_stb), .IACK_A(iack_a), .IACK_END(iack_end),
    .INT_PEND(pend[0]), .INT_LEVEL(level[0]), .nVPA(vpa_n[0]), .nBERR(berr_n[0]),
    .VECTOR(vector[0]), .WR_ACK(wr_ack[0]), .ACK_BITS(bits[0]));

  irq_iack_resp #(.AUTO_ACK(1), .CLR_TIMEOUT(TMO)) dut_auto (
    .CLK(clk), .nRESET(nreset), .CLK_EN(clk_en), .IPL0(ipl0), .IPL1(ipl1),
    .IMASK(imask), .IACK_STB(iack_stb), .IACK_A(iack_a), .IACK_END(iack_end),
    .INT_PEND(pend[1]), .INT_LEVEL(level[1]), .nVPA(vpa_n[1]), .nBERR(berr_n[1]),
    .VECTOR(vector[1]), .WR_ACK(wr_ack[1]), .ACK_BITS(bits[1]));

  function automatic logic [17:0] pack(input logic p, input logic [2:0] l,
                                       input logic v, input logic b,
                                       input logic [7:0] vec, input logic w,
                                       input logic [2:0] ab);
    return {p, l, v, b, vec, w, ab};
  endfunction

  function automatic logic [17:0] obs(input int i);
    return pack(pend[i], level[i], vpa_n[i], berr_n[i], vector[i], wr_ack[i], bits[i]);
  endfunction

  localparam logic [17:0] RST_OBS = {1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pend|lvl|vpa|berr|vec|wr|bits packed)",
               name, got, exp);
    end
  endtask

  // Drive inputs; lv is the interrupt level put on the active-low IPL pair.
  task automatic drive(input int lv, input bit en, input int mask,
                       input bit stb, input int a, input bit iend);
    logic [1:0] l;
    l        = 2'(lv);
    ipl1     = ~l[1];
    ipl0     = ~l[0];
    clk_en   = en;
    imask    = 3'(mask);
    iack_stb = stb;
    iack_a   = 3'(a);
    iack_end = iend;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  // ---------------- vector table (checked on the auto-ack instance) -------
  typedef struct {
    int lv; bit en; int mask; bit stb; int a; bit iend;
    logic [17:0] exp;
  } row_t;
  row_t tbl[$];

  task automatic add(input int lv, input bit en, input int mask, input bit stb,
                     input int a, input bit iend, input bit p, input int l,
                     input bit v, input bit b, input int vec, input bit w,
                     input int ab);
    row_t r;
    r.lv = lv; r.en = en; r.mask = mask; r.stb = stb; r.a = a; r.iend = iend;
    r.exp = pack(p, 3'(l), v, b, 8'(vec), w, 3'(ab));
    tbl.push_back(r);
  endtask

  // ---------------- behavioural reference model ---------------------------
  logic [2:0] hist[$];
  logic [2:0] m_lvl;
  bit         m_in_iack [2];
  bit         m_iack_ok [2];
  bit         m_ack_due [2];
  bit         m_clearing[2];
  int         m_waits   [2];
  logic [2:0] m_acked   [2];
  logic       m_pend    [2];
  logic [2:0] m_level   [2];
  logic       m_vpa     [2];
  logic       m_berr    [2];
  logic [7:0] m_vec     [2];
  logic       m_wr      [2];
  logic [2:0] m_bits    [2];

  task automatic model_reset();
    hist = '{3'd0, 3'd0};
    m_lvl = 3'd0;
    for (int i = 0; i < 2; i++) begin
      m_in_iack[i] = 0; m_iack_ok[i] = 0; m_ack_due[i] = 0; m_clearing[i] = 0;
      m_waits[i] = 0; m_acked[i] = 3'd0;
      m_pend[i] = 1'b0; m_level[i] = 3'd0; m_vpa[i] = 1'b1; m_berr[i] = 1'b1;
      m_vec[i] = 8'h00; m_wr[i] = 1'b0; m_bits[i] = 3'd0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step(input int lv);
    logic [2:0] cur;
    bit         p;
    cur = m_lvl;
    for (int i = 0; i < 2; i++) begin
      p = (cur != 0) && (cur > imask) && !(m_clearing[i] && cur == m_acked[i]);
      m_wr[i]   = 1'b0;
      m_bits[i] = 3'd0;
      if (m_in_iack[i]) begin
        if (iack_end) begin
          m_in_iack[i] = 0;
          if (m_iack_ok[i]) begin
            m_vpa[i] = 1'b1;
            if (i == 1) m_ack_due[i] = 1;
          end else begin
            m_berr[i] = 1'b1;
          end
        end
      end else if (m_ack_due[i]) begin
        m_wr[i]       = 1'b1;
        m_bits[i]     = 3'(1 << (3 - int'(m_acked[i])));
        m_ack_due[i]  = 0;
        m_clearing[i] = 1;
        m_waits[i]    = 0;
      end else if (m_clearing[i]) begin
        if (cur != m_acked[i]) m_clearing[i] = 0;
        else if (clk_en) begin
          m_waits[i]++;
          if (m_waits[i] == int'(TMO)) m_clearing[i] = 0;
        end
      end else if (iack_stb) begin
        m_in_iack[i] = 1;
        if (iack_a == m_level[i] && iack_a != 0) begin
          m_iack_ok[i] = 1;
          m_acked[i]   = iack_a;
          m_vec[i]     = 8'h18 + 8'(iack_a);
          m_vpa[i]     = 1'b0;
        end else begin
          m_iack_ok[i] = 0;
          m_vec[i]     = 8'h18;
          m_berr[i]    = 1'b0;
        end
      end
      m_pend[i]  = p;
      m_level[i] = p ? cur : 3'd0;
    end
    if (hist[0] == hist[1]) m_lvl = hist[0];
    if (clk_en) begin
      hist.push_front(3'(lv));
      void'(hist.pop_back());
    end
  endtask

  function automatic logic [17:0] model_obs(input int i);
    return pack(m_pend[i], m_level[i], m_vpa[i], m_berr[i], m_vec[i], m_wr[i], m_bits[i]);
  endfunction

  initial begin
    nreset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    @(negedge clk);
    check("reset_man",  32'(obs(0)), 32'(RST_OBS));
    check("reset_auto", 32'(obs(1)), 32'(RST_OBS));

    //  lv en mk stb a end | pend lvl vpa berr vec  wr bits
    add(2, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h00, 0, 0);
    add(2, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h00, 0, 0);
    add(2, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h00, 0, 0);
    add(2, 0, 0, 0, 0, 0,   1, 2, 1, 1, 'h00, 0, 0);
    add(2, 0, 0, 1, 2, 0,   1, 2, 0, 1, 'h1A, 0, 0);
    add(2, 0, 0, 0, 0, 0,   1, 2, 0, 1, 'h1A, 0, 0);
    add(2, 0, 0, 0, 0, 1,   1, 2, 1, 1, 'h1A, 0, 0);
    add(2, 0, 0, 0, 0, 0,   1, 2, 1, 1, 'h1A, 1, 'b010);
    add(2, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(2, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(2, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(2, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(2, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(2, 0, 0, 0, 0, 0,   1, 2, 1, 1, 'h1A, 0, 0);
    add(2, 0, 0, 1, 2, 0,   1, 2, 0, 1, 'h1A, 0, 0);
    add(2, 0, 0, 1, 2, 1,   1, 2, 1, 1, 'h1A, 0, 0);
    add(2, 0, 0, 0, 0, 0,   1, 2, 1, 1, 'h1A, 1, 'b010);
    add(2, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h1A, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 'h18, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 'h18, 0, 0);
    add(1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(1, 0, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(1, 0, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(3, 1, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(3, 1, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(3, 0, 1, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(3, 0, 1, 0, 0, 0,   1, 3, 1, 1, 'h18, 0, 0);
    add(3, 0, 3, 0, 0, 0,   0, 0, 1, 1, 'h18, 0, 0);
    add(3, 0, 2, 0, 0, 0,   1, 3, 1, 1, 'h18, 0, 0);
    add(3, 0, 2, 1, 2, 0,   1, 3, 1, 0, 'h18, 0, 0);
    add(3, 0, 2, 0, 0, 0,   1, 3, 1, 0, 'h18, 0, 0);
    add(3, 0, 2, 0, 0, 1,   1, 3, 1, 1, 'h18, 0, 0);
    add(3, 0, 2, 0, 0, 0,   1, 3, 1, 1, 'h18, 0, 0);

    foreach (tbl[r]) begin
      drive(tbl[r].lv, tbl[r].en, tbl[r].mask, tbl[r].stb, tbl[r].a, tbl[r].iend);
      @(negedge clk);
      check($sformatf("table_row%0d", r), 32'(obs(1)), 32'(tbl[r].exp));
    end

    // Level-1 autovector on both instances, then reset during IACK_AV.
    do_reset();
    drive(1, 1, 0, 0, 0, 0); @(negedge clk);
    drive(1, 1, 0, 0, 0, 0); @(negedge clk);
    drive(1, 0, 0, 0, 0, 0); @(negedge clk);
    drive(1, 0, 0, 0, 0, 0); @(negedge clk);
    check("l1_pend_man", 32'({pend[0], level[0]}), 32'({1'b1, 3'd1}));
    drive(1, 0, 0, 1, 1, 0); @(negedge clk);
    check("l1_vpa_man", 32'({vpa_n[0], vector[0]}), 32'({1'b0, 8'h19}));
    check("l1_vpa_auto", 32'({vpa_n[1], vector[1]}), 32'({1'b0, 8'h19}));
    drive(1, 0, 0, 0, 0, 1); @(negedge clk);
    check("l1_end_man", 32'(vpa_n[0]), 32'(1));
    check("l1_end_auto", 32'(vpa_n[1]), 32'(1));
    drive(1, 0, 0, 0, 0, 0); @(negedge clk);
    check("noack_man", 32'({wr_ack[0], bits[0], pend[0]}), 32'({1'b0, 3'd0, 1'b1}));
    check("ack_auto", 32'({wr_ack[1], bits[1]}), 32'({1'b1, 3'b100}));
    drive(1, 0, 0, 0, 0, 0); @(negedge clk);
    check("supp_auto", 32'({wr_ack[1], pend[1]}), 32'({1'b0, 1'b0}));
    check("nosupp_man", 32'(pend[0]), 32'(1));
    drive(1, 0, 0, 1, 1, 0); @(negedge clk);
    check("reiack_man", 32'(vpa_n[0]), 32'(0));
    check("stb_ignored_auto", 32'(vpa_n[1]), 32'(1));
    nreset = 1'b0;
    #1;
    check("async_rst_man", 32'(obs(0)), 32'(RST_OBS));
    check("async_rst_auto", 32'(obs(1)), 32'(RST_OBS));
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nreset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_man%0d", c), 32'(obs(0)), 32'(RST_OBS));
      check($sformatf("post_rst_auto%0d", c), 32'(obs(1)), 32'(RST_OBS));
    end

    // Randomized run against the reference model.
    begin
      int lv;
      lv = 0;
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++)
          check($sformatf("rand_c%0d_i%0d", c, i), 32'(obs(i)), 32'(model_obs(i)));
        if (c == 1500) begin
          nreset = 1'b0;
          #1;
          model_reset();
          for (int i = 0; i < 2; i++)
            check($sformatf("rand_rst_i%0d", i), 32'(obs(i)), 32'(model_obs(i)));
          @(negedge clk);
          nreset = 1'b1;
        end
        if ($urandom_range(0, 9) == 0) lv = $urandom_range(0, 3);
        clk_en = ($urandom_range(0, 1) == 1);
        {ipl1, ipl0} = ~2'(lv);
        if ($urandom_range(0, 29) == 0) imask = 3'($urandom_range(0, 7));
        iack_stb = ($urandom_range(0, 9) == 0);
        iack_end = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 1) == 1) iack_a = m_level[$urandom_range(0, 1)];
        else                           iack_a = 3'($urandom_range(0, 7));
        model_step(lv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
